// File: rtl/pipelined_control_unit_if.sv
// Decode-stage handshake: instruction key in, registered control bundle out.
// master = fetch/instruction-register side, slave = decode stage.
interface pipelined_control_unit_if #(
  parameter int OPCODE_W   = 3,
  parameter int ALU_CTRL_W = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            inst_type;
  logic [1:0]            dir_mode;
  logic [OPCODE_W-1:0]   opcode;
  logic                  out_valid;
  logic [1:0]            result_source;
  logic                  alu_source;
  logic                  mem_write;
  logic                  reg_write;
  logic                  jump;
  logic                  branch;
  logic                  is_rd;
  logic                  imm_src;
  logic [ALU_CTRL_W-1:0] alu_control;
  logic                  illegal;

  modport master (
    output in_valid, inst_type, dir_mode, opcode,
    input  in_ready, out_valid, result_source, alu_source,
    input  mem_write, reg_write, jump, branch, is_rd, imm_src,
    input  alu_control, illegal
  );

  modport slave (
    input  in_valid, inst_type, dir_mode, opcode,
    output in_ready, out_valid, result_source, alu_source,
    output mem_write, reg_write, jump, branch, is_rd, imm_src,
    output alu_control, illegal
  );
endinterface

// File: rtl/pipelined_control_unit.sv
// Registered decode stage with ID/EX bundle, mul/div occupancy and flush.
// CU_PERF_CNT_EN enables the saturating stall_cycles perf counter.
module pipelined_control_unit #(
  parameter int OPCODE_W      = 3,
  parameter int ALU_CTRL_W    = 3,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  pipelined_control_unit_if.slave bus,
  input  logic                    stall,
  input  logic                    flush,
  output logic                    busy,
  output logic [15:0]             stall_cycles
);

  typedef struct packed {
    logic [1:0]            result_source;
    logic                  alu_source;
    logic                  mem_write;
    logic                  reg_write;
    logic                  jump;
    logic                  branch;
    logic                  is_rd;
    logic                  imm_src;
    logic [ALU_CTRL_W-1:0] alu_control;
  } ctrl_t;

  localparam int CNT_W =
    (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(MULDIV_CYCLES - 1);

  localparam logic [OPCODE_W-1:0] OP_0 = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_1 = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_2 = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_3 = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_4 = OPCODE_W'(4);

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = '0;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL = ALU_CTRL_W'(5);
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL = ALU_CTRL_W'(6);

  logic [1:0]          dm;
  logic [1:0]          it;
  logic [OPCODE_W-1:0] op;

  assign dm = bus.dir_mode;
  assign it = bus.inst_type;
  assign op = bus.opcode;

  logic k_r;
  logic k_imm;
  logic k_sb;
  logic k_ld;
  logic k_jalr;
  logic k_br;
  logic k_lui;
  logic k_jal;
  logic k_mul;

  assign k_r    = dm == 2'b00 && it == 2'b00
               && op <= OP_4;
  assign k_imm  = dm == 2'b01 && it == 2'b00
               && op <= OP_2;
  assign k_sb   = dm == 2'b01 && it == 2'b01
               && op == OP_0;
  assign k_ld   = dm == 2'b01 && it == 2'b01
               && op >= OP_1 && op <= OP_3;
  assign k_jalr = dm == 2'b01 && it == 2'b10
               && op == OP_0;
  assign k_br   = dm == 2'b01 && it == 2'b10
               && op >= OP_1 && op <= OP_4;
  assign k_lui  = dm == 2'b10 && it == 2'b00
               && op == OP_0;
  assign k_jal  = dm == 2'b10 && it == 2'b10
               && op == OP_0;
  assign k_mul  = k_r && op >= OP_2;

  ctrl_t dec;
  logic  legal;

  // Key predicates above are mutually exclusive by construction.
  always_comb begin
    dec   = '0;
    legal = 1'b1;
    unique case (1'b1)
      k_r: begin
        dec.reg_write   = 1'b1;
        dec.is_rd       = 1'b1;
        dec.alu_control = ALU_CTRL_W'(op);
      end
      k_imm: begin
        dec.alu_source  = 1'b1;
        dec.reg_write   = 1'b1;
        dec.is_rd       = 1'b1;
        dec.alu_control = (op == OP_1) ? ALU_SLL
                        : (op == OP_2) ? ALU_SRL
                        : ALU_ADD;
      end
      k_sb: begin
        dec.alu_source = 1'b1;
        dec.mem_write  = 1'b1;
      end
      k_ld: begin
        dec.result_source = 2'b01;
        dec.alu_source    = 1'b1;
        dec.reg_write     = 1'b1;
        dec.is_rd         = 1'b1;
      end
      k_jalr: begin
        dec.result_source = 2'b10;
        dec.alu_source    = 1'b1;
        dec.reg_write     = 1'b1;
        dec.jump          = 1'b1;
        dec.is_rd         = 1'b1;
      end
      k_br: begin
        dec.branch = 1'b1;
      end
      k_lui: begin
        dec.alu_source  = 1'b1;
        dec.reg_write   = 1'b1;
        dec.is_rd       = 1'b1;
        dec.imm_src     = 1'b1;
        dec.alu_control = ALU_SLL;
      end
      k_jal: begin
        dec.alu_source  = 1'b1;
        dec.reg_write   = 1'b1;
        dec.jump        = 1'b1;
        dec.is_rd       = 1'b1;
        dec.imm_src     = 1'b1;
        dec.alu_control = ALU_ADD;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  logic             out_valid_q;
  logic             illegal_q;
  ctrl_t            ctrl_q;
  logic [CNT_W-1:0] cnt_q;
  logic             take;

  assign busy         = cnt_q != '0;
  assign bus.in_ready = !busy && !stall;
  assign take         = bus.in_valid && legal;

  // Occupancy keeps counting through stall; flush aborts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      ctrl_q      <= '0;
      cnt_q       <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      ctrl_q      <= '0;
      cnt_q       <= '0;
    end else begin
      if (bus.in_ready) begin
        out_valid_q <= take;
        illegal_q   <= bus.in_valid && !legal;
        ctrl_q      <= take ? dec : '0;
      end
      if (bus.in_ready && bus.in_valid && k_mul)
        cnt_q <= CNT_LOAD;
      else if (busy)
        cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.illegal       = illegal_q;
  assign bus.result_source = ctrl_q.result_source;
  assign bus.alu_source    = ctrl_q.alu_source;
  assign bus.mem_write     = ctrl_q.mem_write;
  assign bus.reg_write     = ctrl_q.reg_write;
  assign bus.jump          = ctrl_q.jump;
  assign bus.branch        = ctrl_q.branch;
  assign bus.is_rd         = ctrl_q.is_rd;
  assign bus.imm_src       = ctrl_q.imm_src;
  assign bus.alu_control   = ctrl_q.alu_control;

`ifdef CU_PERF_CNT_EN
  logic [15:0] perf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      perf_q <= '0;
    else if (bus.in_valid && !bus.in_ready && !flush
             && perf_q != 16'hFFFF)
      perf_q <= perf_q + 16'd1;
  end

  assign stall_cycles = perf_q;
`else
  assign stall_cycles = '0;
`endif

endmodule
